barrel_shift_pipe: RTL
======================

// Module: barrel_shift_pipe
// PURPOSE
//  Parametrised, pipelined barrel shifter: next generation of the 8-bit rotate-right shifter.
//  Width is generic. Four modes: ROR, ROL, LSR, ASR. Carry-out and zero flags on the result.
//  Valid/ready streaming handshake on input and output, with full backpressure.
//  Sits between an operand source (regfile/ALU issue) and a result sink; one op accepted per clock.
// PARAMETERS
//  DATA_W   8   data width; power of two, >=2
//  SH_W     $clog2(DATA_W)  shift-amount width = number of log stages (derived, do not override)
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       operand valid
//  in_ready   out  1       block can accept operand this cycle
//  in_data    in   DATA_W  operand
//  in_shamt   in   SH_W    shift/rotate amount, 0..DATA_W-1
//  in_mode    in   2       00 ROR, 01 ROL, 10 LSR (zero fill), 11 ASR (sign fill)
//  out_valid  out  1       result valid
//  out_ready  in   1       sink accepts result
//  out_data   out  DATA_W  shifted result
//  out_carry  out  1       last bit moved past the end (see below)
//  out_zero   out  1       out_data == 0
// BEHAVIOUR
//  - Clock is clk; reset is synchronous and active-high; no other clock or reset.
//  - Datapath: SH_W stages. Stage k shifts by 2^k when shamt[k]=1; otherwise it passes data through.
//  - Each stage has a register carrying valid, data, the remaining shamt bits, mode, and carry so far.
//  - Latency: exactly SH_W cycles from accept (in_valid&in_ready) to out_valid with no stall.
//  - Throughput: 1 op/clk.
//  - Handshake: a transfer occurs when valid&ready are both high on a rising edge.
//  - out_valid/out_data/out_carry/out_zero are held stable while out_valid&!out_ready.
//  - Per-stage advance: stage k loads when (!valid[k] | advance[k+1]). The last stage advances on out_ready.
//  - Bubbles collapse under stall. in_ready = stage-0 advance condition (combinational from downstream).
//  - out_valid never depends on out_ready in the same cycle.
//  - Modes:
//     ROR  res = {d, d} >> s, low DATA_W bits
//     ROL  res = {d, d} << s, high DATA_W bits
//     LSR  res = d >> s, zero fill
//     ASR  res = d >>> s, fill with d[DATA_W-1]
//  - out_carry:
//     LSR/ASR  = d[s-1]
//     ROR      = res[DATA_W-1]
//     ROL      = res[0]
//     s==0     = 0 in every mode
//  - out_zero is registered with the final stage and is not recomputed combinationally after the register.
//  - shamt wraps naturally mod DATA_W. No saturation; full-width shifts are not representable.
//  - Reset: all stage valids=0, out_valid=0, out_data=0, out_carry=0, out_zero=0.
//  - Reset mid-operation: all in-flight ops are discarded with no output.
//  - in_ready may be 1 during reset (stages empty); the sink sees no out_valid until SH_W cycles after the first post-reset accept.
//  - Simultaneous accept and emit in the same cycle is legal and required for full throughput.
// STRUCTURE
//  - Shared package barrel_pkg holds:
//     mode constants MODE_ROR=2'd0, MODE_ROL=2'd1, MODE_LSR=2'd2, MODE_ASR=2'd3
//     the stage payload struct (data, shamt, mode, carry)
//  - One sub-module: barrel_stage #(DATA_W, SHIFT) containing one conditional shift-by-SHIFT mux, its carry update, and its pipeline register with valid/advance.
//  - Top instantiates SH_W stages in a generate loop, SHIFT=2^k.
// TESTING (DATA_W=8, latency 3)
//  1. 0xB4 with each mode, s=3, out_ready=1:
//     ROR -> 0x96 c1
//     ROL -> 0xA5 c1
//     LSR -> 0x16 c1
//     ASR -> 0xF6 c1
//     each result appears exactly 3 clk after accept.
//  2. 0x01 LSR s=1 -> 0x00, carry=1, zero=1. Any mode with s=0 -> data unchanged, carry=0.
//  3. Back-to-back stream of 16 ops with out_ready=1 -> 16 results in order, one per clk, in_ready stays 1.
//  4. out_ready=0 for 6 clk mid-stream:
//     after 3 ops fill the pipe, in_ready drops
//     out_* holds stable
//     on release, no op is lost or duplicated, and order is preserved.
//  5. reset pulsed for 1 clk with 2 ops in flight -> out_valid=0 next clk and all outputs 0; the dropped ops never appear.
//  6. Random mode/shamt/data with random out_ready, checked against a reference model; scoreboard count equals accepted count.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift modes and the
// width-independent part of the per-stage payload.
package barrel_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ROR = 2'd0;  // rotate right
  localparam mode_t MODE_ROL = 2'd1;  // rotate left
  localparam mode_t MODE_LSR = 2'd2;  // logical shift right, zero fill
  localparam mode_t MODE_ASR = 2'd3;  // arithmetic shift right, sign fill

  // Mode and carry-so-far travel with every op. Data and shamt widths depend on
  // the instance width, so each stage keeps those beside this struct.
  typedef struct packed {
    mode_t mode;
    logic  carry;
  } stage_meta_t;

endpackage

// File: rtl/barrel_stage.sv
// One log stage of the barrel shifter: conditional shift by SHIFT, carry
// update, and a pipeline register with valid/advance flow control.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SHIFT  = 1,
  parameter int unsigned SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  // upstream side
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [SH_W-1:0]   up_shamt,
  input  logic [1:0]        up_mode,
  input  logic              up_carry,
  // downstream side
  output logic              valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] data,
  output logic [SH_W-1:0]   shamt,
  output logic [1:0]        mode,
  output logic              carry,
  output logic              zero
);

  // shamt bit that enables this stage
  localparam int unsigned Bit = $clog2(SHIFT);

  logic              valid_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SH_W-1:0]   shamt_q;
  stage_meta_t       meta_q, meta_d;
  logic              zero_q;
  logic              load;

  // Load when empty or when the occupant moves on this cycle; bubbles collapse.
  assign load     = !valid_q || dn_ready;
  assign up_ready = load;

  // Conditional shift by SHIFT; carry tracks the bit that crossed the end last.
  always_comb begin
    data_d = up_data;
    meta_d = '{mode: up_mode, carry: up_carry};
    if (up_shamt[Bit]) begin
      unique case (up_mode)
        MODE_ROR: begin
          data_d       = {up_data[SHIFT-1:0], up_data[DATA_W-1:SHIFT]};
          meta_d.carry = up_data[SHIFT-1];  // new MSB
        end
        MODE_ROL: begin
          data_d       = {up_data[DATA_W-SHIFT-1:0], up_data[DATA_W-1:DATA_W-SHIFT]};
          meta_d.carry = up_data[DATA_W-SHIFT];  // new LSB
        end
        MODE_LSR: begin
          data_d       = {{SHIFT{1'b0}}, up_data[DATA_W-1:SHIFT]};
          meta_d.carry = up_data[SHIFT-1];
        end
        default: begin  // MODE_ASR
          data_d       = {{SHIFT{up_data[DATA_W-1]}}, up_data[DATA_W-1:SHIFT]};
          meta_d.carry = up_data[SHIFT-1];
        end
      endcase
    end
  end

  // Pipeline register; payload only changes when a real op is loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      meta_q  <= '0;
      zero_q  <= 1'b0;
    end else if (load) begin
      valid_q <= up_valid;
      if (up_valid) begin
        data_q  <= data_d;
        shamt_q <= up_shamt;
        meta_q  <= meta_d;
        zero_q  <= (data_d == '0);
      end
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign shamt = shamt_q;
  assign mode  = meta_q.mode;
  assign carry = meta_q.carry;
  assign zero  = zero_q;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter (ROR/ROL/LSR/ASR) with carry and zero flags and a
// valid/ready stream on both sides. One log stage per shamt bit, SH_W cycles.
module barrel_shift_pipe
  import barrel_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SH_W-1:0]   in_shamt,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_carry,
  output logic              out_zero
);

  if (DATA_W < 2 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_width
    $error("barrel_shift_pipe: DATA_W must be a power of two >= 2");
  end

  // Entry 0 is the input port, entry k+1 the output of stage k.
  logic              st_valid [SH_W+1];
  logic              st_ready [SH_W+1];
  logic [DATA_W-1:0] st_data  [SH_W+1];
  logic [SH_W-1:0]   st_shamt [SH_W+1];
  logic [1:0]        st_mode  [SH_W+1];
  logic              st_carry [SH_W+1];
  logic              st_zero  [SH_W];

  assign st_valid[0]    = in_valid;
  assign st_data[0]     = in_data;
  assign st_shamt[0]    = in_shamt;
  assign st_mode[0]     = in_mode;
  assign st_carry[0]    = 1'b0;  // s==0 leaves carry clear in every mode
  assign st_ready[SH_W] = out_ready;

  for (genvar k = 0; k < SH_W; k++) begin : g_stage
    barrel_stage #(
      .DATA_W (DATA_W),
      .SHIFT  (2 ** k),
      .SH_W   (SH_W)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .up_valid (st_valid[k]),
      .up_ready (st_ready[k]),
      .up_data  (st_data[k]),
      .up_shamt (st_shamt[k]),
      .up_mode  (st_mode[k]),
      .up_carry (st_carry[k]),
      .valid    (st_valid[k+1]),
      .dn_ready (st_ready[k+1]),
      .data     (st_data[k+1]),
      .shamt    (st_shamt[k+1]),
      .mode     (st_mode[k+1]),
      .carry    (st_carry[k+1]),
      .zero     (st_zero[k])
    );
  end

  // in_ready is the stage-0 load condition, combinational from downstream.
  assign in_ready  = st_ready[0];
  assign out_valid = st_valid[SH_W];
  assign out_data  = st_data[SH_W];
  assign out_carry = st_carry[SH_W];
  assign out_zero  = st_zero[SH_W-1];

  // A result held by a stalled sink must not change until it is taken.
  assert property (@(posedge clk) disable iff (reset)
    out_valid && !out_ready |=> out_valid && $stable(out_data) && $stable(out_carry)
                                && $stable(out_zero));

endmodule
